time_of_day_core: RTL

Parametrised time-of-day engine for the board clock design. It replaces the fixed 1 Hz divider plus minute/second counter pair with a single block. The block contains:
- a configurable tick prescaler;
- a cascaded BCD hours:minutes:seconds counter with 12/24-hour mode;
- a button-driven set-mode state machine.

It sits between the board clock and the seven-segment decoders, which consume its BCD outputs.

---
 rtl/tod_pkg.sv | 36 +++
 rtl/bcd_mod_counter.sv | 51 +++++
 rtl/time_of_day_core.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tod_pkg.sv
// tod_pkg: shared definitions for the time-of-day engine.
// Holds the FSM state encoding, BCD limit constants, the legal HOUR_MODE
// values and a two-digit BCD increment helper.
package tod_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_SET_AL  = 2'b11
  } tod_state_e;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  localparam int HOUR_MODE_24 = 24;
  localparam int HOUR_MODE_12 = 12;

  // Two-digit BCD increment with wrap from vmax back to vmin.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] vmax,
                                         input logic [7:0] vmin);
    if (v == vmax) begin
      return vmin;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping MAX_VAL -> MIN_VAL.
// clear has priority over load, load over inc. carry_o flags an increment
// taken at MAX_VAL, independent of clear, so a coincident clear never
// swallows the carry into the next field.
module bcd_mod_counter
  import tod_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = BCD_59,
  parameter logic [7:0] MIN_VAL = BCD_00,
  parameter logic [7:0] RST_VAL = BCD_00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] q_o,
  output logic [7:0] d_o,
  output logic       carry_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear, then load, then BCD increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = MIN_VAL;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = bcd_inc(cnt_q, MAX_VAL, MIN_VAL);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o     = cnt_q;
  assign d_o     = cnt_d;
  assign carry_o = inc_i & (cnt_q == MAX_VAL);

endmodule

// File: rtl/time_of_day_core.sv
// time_of_day_core: tick prescaler, cascaded BCD hh:mm:ss with 12/24-hour
// mode, and a button-driven set-mode FSM.
// Optional feature macro: TOD_ALARM_EN adds the SET_AL state, alarm
// hour/minute registers and the alarm_hit output.
module time_of_day_core
  import tod_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int HOUR_MODE = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       pm,
  output logic [1:0] state,
  output logic       tick,
  output logic       day_wrap,
  input  logic       alarm_arm,
  output logic       alarm_hit
);

  localparam int         DIV    = CLK_HZ / TICK_HZ;
  localparam int         PW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);
  localparam bit         IS_12H = (HOUR_MODE == HOUR_MODE_12);
  localparam logic [7:0] HR_MIN = IS_12H ? BCD_01 : BCD_00;
  localparam logic [7:0] HR_MAX = IS_12H ? BCD_12 : BCD_23;
  localparam logic [7:0] HR_RST = IS_12H ? BCD_12 : BCD_00;

  if (HOUR_MODE != HOUR_MODE_24 && HOUR_MODE != HOUR_MODE_12) begin : g_bad_hour_mode
    $error("time_of_day_core: HOUR_MODE must be 12 or 24");
  end
  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_divider
    $error("time_of_day_core: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic [2:0] mode_sync_q, inc_sync_q;
  logic       mode_pulse_q, inc_pulse_q;
  logic       mode_evt, inc_evt, enter_set_hr, run_adv;
  tod_state_e state_q;
  logic [PW-1:0] pre_q;
  logic       tick_q;
  logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic       sec_carry, min_carry, hr_carry;
  logic       set_hr_inc, set_min_inc, hr_inc_run, hr_inc;
  logic       pm_q, pm_d, day_wrap_q, day_wrap_d;
  logic       unused_common;

  // Two-flop synchroniser plus registered rising-edge pulse per button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sync_q  <= 3'b000;
      inc_sync_q   <= 3'b000;
      mode_pulse_q <= 1'b0;
      inc_pulse_q  <= 1'b0;
    end else begin
      mode_sync_q  <= {mode_sync_q[1:0], btn_mode};
      inc_sync_q   <= {inc_sync_q[1:0], btn_inc};
      mode_pulse_q <= mode_sync_q[1] & ~mode_sync_q[2];
      inc_pulse_q  <= inc_sync_q[1] & ~inc_sync_q[2];
    end
  end

  // A mode edge always wins over a coincident increment edge.
  assign mode_evt     = mode_pulse_q;
  assign inc_evt      = inc_pulse_q & ~mode_pulse_q;
  assign enter_set_hr = mode_evt & (state_q == ST_RUN);
  assign run_adv      = en & (state_q == ST_RUN) & ~mode_evt;

`ifdef TOD_ALARM_EN
  logic al_min_sel_q;
`endif

  // Set-mode state machine, advanced by each mode-button pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
`ifdef TOD_ALARM_EN
      al_min_sel_q <= 1'b0;
`endif
    end else if (mode_evt) begin
      case (state_q)
        ST_RUN:    state_q <= ST_SET_HR;
        ST_SET_HR: state_q <= ST_SET_MIN;
`ifdef TOD_ALARM_EN
        ST_SET_MIN: begin
          state_q      <= ST_SET_AL;
          al_min_sel_q <= 1'b0;
        end
        ST_SET_AL: begin
          if (!al_min_sel_q) begin
            al_min_sel_q <= 1'b1;
          end else begin
            al_min_sel_q <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
`else
        ST_SET_MIN: state_q <= ST_RUN;
`endif
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  // Prescaler: runs only in RUN with en high, cleared on entry to SET_HR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (enter_set_hr) begin
        pre_q <= '0;
      end else if (run_adv) begin
        if (pre_q == TERM) begin
          pre_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  // tick_q is only ever high while state_q is still RUN, so the cascade
  // below never advances during a SET state; set-mode edits never carry.
  assign set_hr_inc  = inc_evt & (state_q == ST_SET_HR);
  assign set_min_inc = inc_evt & (state_q == ST_SET_MIN);
  assign hr_inc_run  = sec_carry & min_carry;
  assign hr_inc      = hr_inc_run | set_hr_inc;

  bcd_mod_counter #(.MAX_VAL(BCD_59), .MIN_VAL(BCD_00), .RST_VAL(BCD_00)) u_sec (
    .clk(clk), .rst(rst), .inc_i(tick_q), .clear_i(enter_set_hr),
    .load_i(1'b0), .load_val_i(BCD_00),
    .q_o(sec_q), .d_o(sec_d), .carry_o(sec_carry)
  );

  bcd_mod_counter #(.MAX_VAL(BCD_59), .MIN_VAL(BCD_00), .RST_VAL(BCD_00)) u_min (
    .clk(clk), .rst(rst), .inc_i(sec_carry | set_min_inc), .clear_i(1'b0),
    .load_i(1'b0), .load_val_i(BCD_00),
    .q_o(min_q), .d_o(min_d), .carry_o(min_carry)
  );

  bcd_mod_counter #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_hr (
    .clk(clk), .rst(rst), .inc_i(hr_inc), .clear_i(1'b0),
    .load_i(1'b0), .load_val_i(HR_RST),
    .q_o(hr_q), .d_o(hr_d), .carry_o(hr_carry)
  );

  // PM toggles on every 11->12 step (run or set); day wrap only on a run carry
  always_comb begin
    pm_d       = pm_q;
    day_wrap_d = 1'b0;
    if (IS_12H) begin
      if (hr_inc && (hr_q == BCD_11)) begin
        pm_d = ~pm_q;
      end
      day_wrap_d = hr_inc_run & (hr_q == BCD_11) & pm_q;
    end else begin
      day_wrap_d = hr_inc_run & (hr_q == BCD_23);
    end
  end

  // PM flag and day-wrap pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q       <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      pm_q       <= pm_d;
      day_wrap_q <= day_wrap_d;
    end
  end

`ifdef TOD_ALARM_EN
  logic [7:0] al_hr_q, al_hr_d, al_min_q, al_min_d;
  logic       al_hr_carry, al_min_carry, al_hr_inc, al_min_inc;
  logic       al_pm_q, al_pm_d, run_next, alarm_hit_q, alarm_hit_d;
  logic       unused_alarm;

  assign al_hr_inc  = inc_evt & (state_q == ST_SET_AL) & ~al_min_sel_q;
  assign al_min_inc = inc_evt & (state_q == ST_SET_AL) & al_min_sel_q;

  bcd_mod_counter #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_al_hr (
    .clk(clk), .rst(rst), .inc_i(al_hr_inc), .clear_i(1'b0),
    .load_i(1'b0), .load_val_i(HR_RST),
    .q_o(al_hr_q), .d_o(al_hr_d), .carry_o(al_hr_carry)
  );

  bcd_mod_counter #(.MAX_VAL(BCD_59), .MIN_VAL(BCD_00), .RST_VAL(BCD_00)) u_al_min (
    .clk(clk), .rst(rst), .inc_i(al_min_inc), .clear_i(1'b0),
    .load_i(1'b0), .load_val_i(BCD_00),
    .q_o(al_min_q), .d_o(al_min_d), .carry_o(al_min_carry)
  );

  // Match is evaluated on next-state values so alarm_hit lines up with the
  // displayed time rather than trailing it by a cycle.
  assign run_next = ((state_q == ST_RUN) & ~mode_evt) |
                    ((state_q == ST_SET_AL) & al_min_sel_q & mode_evt);

  // Alarm PM walk and registered match
  always_comb begin
    al_pm_d = al_pm_q;
    if (IS_12H && al_hr_inc && (al_hr_q == BCD_11)) begin
      al_pm_d = ~al_pm_q;
    end
    alarm_hit_d = alarm_arm & run_next & (hr_d == al_hr_d) &
                  (min_d == al_min_d) & (pm_d == al_pm_d);
  end

  // Alarm PM flag and alarm_hit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_pm_q     <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      al_pm_q     <= al_pm_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign alarm_hit    = alarm_hit_q;
  assign unused_alarm = ^{al_min_q, al_hr_carry, al_min_carry};
`else
  logic unused_noalarm;
  assign alarm_hit      = 1'b0;
  assign unused_noalarm = ^{alarm_arm, hr_d, min_d};
`endif

  assign unused_common = ^{sec_d, hr_carry};

  assign sec_bcd  = sec_q;
  assign min_bcd  = min_q;
  assign hr_bcd   = hr_q;
  assign pm       = pm_q;
  assign state    = state_q;
  assign tick     = tick_q;
  assign day_wrap = day_wrap_q;

endmodule
